// File: rtl/usrt_apb_ctrl.sv
// usrt_apb_ctrl: APB slave that turns each DATA access into one 8-bit USRT frame.
// Define USRT_PARITY_EN to add an even parity bit after D7 (11-bit frames).
module usrt_apb_ctrl #(
    parameter int CLKS_PER_BIT = 40,
    parameter int ADDR_W       = 33,
    parameter int RX_TIMEOUT   = 16
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              pSelect,
    input  logic              pEnable,
    input  logic              pWrite,
    input  logic [ADDR_W-1:0] pAddress,
    input  logic [7:0]        pWData,
    output logic [7:0]        pRData,
    output logic              pReady,
    output logic              pSlvErr,
    output logic              usrt_clk,
    output logic              usrt_tx,
    input  logic              usrt_rx
);

`ifdef USRT_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int WW   = $clog2(RX_TIMEOUT + 1);
    localparam int SW   = NBITS - 1;

    typedef enum logic [2:0] {S_IDLE, S_TX, S_RX, S_STAT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_q, bit_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [7:0]    rxsr_q, rxsr_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          started_q, started_d;
    logic          slverr_q, slverr_d;
    logic          err_q, err_d;
    logic          tx_q, tx_d;
`ifdef USRT_PARITY_EN
    logic          perr_q, perr_d;
`endif

    logic access, bit_end, mid_bit, in_frame, busy;
    logic unused_addr;

    assign unused_addr = ^pAddress[ADDR_W-1:1];
    assign access      = pSelect & pEnable & ~pReady;
    assign in_frame    = (state_q == S_TX) || (state_q == S_RX);
    assign bit_end     = timer_q == TW'(CLKS_PER_BIT - 1);
    assign mid_bit     = timer_q == TW'(HALF);
    assign busy        = state_q != S_IDLE;

`ifdef USRT_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    always_ff @(posedge pClk) begin
        if (!pReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (pAddress[0])  state_d = S_STAT;
                    else if (pWrite)  state_d = S_TX;
                    else              state_d = S_RX;
                end
            end
            S_TX: begin
                if (!pSelect)                                 state_d = S_IDLE;
                else if (bit_end && bit_q == 4'(NBITS - 1))   state_d = S_DONE;
            end
            S_RX: begin
                if (!pSelect) begin
                    state_d = S_IDLE;
                end else if (!started_q) begin
                    if (bit_end && wait_q == WW'(RX_TIMEOUT - 1)) state_d = S_DONE;
                end else if (mid_bit && bit_q == 4'(NBITS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_STAT:  state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pReady   = (state_q == S_DONE) || (state_q == S_STAT);
        pSlvErr  = (state_q == S_DONE) && slverr_q;
        usrt_clk = in_frame && (timer_q < TW'(HALF));
        usrt_tx  = tx_q;
        pRData   = rdata_q;
    end

    // Datapath next-state: timer, shift registers, capture and error tracking
    always_comb begin
        timer_d   = '0;
        bit_d     = bit_q;
        wait_d    = wait_q;
        shift_d   = shift_q;
        rxsr_d    = rxsr_q;
        rdata_d   = rdata_q;
        started_d = started_q;
        slverr_d  = slverr_q;
        err_d     = err_q;
        tx_d      = tx_q;
`ifdef USRT_PARITY_EN
        perr_d    = perr_q;
`endif
        if (in_frame && state_d == state_q) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (pAddress[0]) begin
                        slverr_d = 1'b0;
                        if (!pWrite) begin
                            rdata_d = {6'b0, err_q, busy};
                            err_d   = 1'b0;
                        end
                    end else if (pWrite) begin
`ifdef USRT_PARITY_EN
                        shift_d = {1'b1, even_parity(pWData), pWData};
`else
                        shift_d = {1'b1, pWData};
`endif
                        tx_d  = 1'b0;
                        bit_d = '0;
                    end else begin
                        bit_d     = '0;
                        wait_d    = '0;
                        started_d = 1'b0;
                        rxsr_d    = '0;
`ifdef USRT_PARITY_EN
                        perr_d    = 1'b0;
`endif
                    end
                end
            end
            S_TX: begin
                if (!pSelect) begin
                    tx_d = 1'b1;
                end else if (bit_end) begin
                    if (bit_q == 4'(NBITS - 1)) begin
                        tx_d     = 1'b1;
                        slverr_d = 1'b0;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b1, shift_q[SW-1:1]};
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            S_RX: begin
                if (pSelect) begin
                    if (!started_q) begin
                        if (mid_bit && !usrt_rx) begin
                            started_d = 1'b1;
                            bit_d     = 4'd1;
                        end else if (bit_end) begin
                            if (wait_q == WW'(RX_TIMEOUT - 1)) begin
                                rdata_d  = '0;
                                slverr_d = 1'b1;
                                err_d    = 1'b1;
                            end else begin
                                wait_d = wait_q + 1'b1;
                            end
                        end
                    end else if (mid_bit) begin
                        bit_d = bit_q + 1'b1;
                        if (bit_q <= 4'd8) rxsr_d = {usrt_rx, rxsr_q[7:1]};
`ifdef USRT_PARITY_EN
                        if (bit_q == 4'd9) perr_d = usrt_rx != even_parity(rxsr_q);
                        if (bit_q == 4'(NBITS - 1)) begin
                            rdata_d  = rxsr_q;
                            slverr_d = ~usrt_rx | perr_q;
                            err_d    = err_q | ~usrt_rx | perr_q;
                        end
`else
                        if (bit_q == 4'(NBITS - 1)) begin
                            rdata_d  = rxsr_q;
                            slverr_d = ~usrt_rx;
                            err_d    = err_q | ~usrt_rx;
                        end
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pClk) begin
        if (!pReset) begin
            timer_q   <= '0;
            bit_q     <= '0;
            wait_q    <= '0;
            shift_q   <= '0;
            rxsr_q    <= '0;
            rdata_q   <= '0;
            started_q <= 1'b0;
            slverr_q  <= 1'b0;
            err_q     <= 1'b0;
            tx_q      <= 1'b1;
`ifdef USRT_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            wait_q    <= wait_d;
            shift_q   <= shift_d;
            rxsr_q    <= rxsr_d;
            rdata_q   <= rdata_d;
            started_q <= started_d;
            slverr_q  <= slverr_d;
            err_q     <= err_d;
            tx_q      <= tx_d;
`ifdef USRT_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

endmodule

// File: tb/tb_usrt_apb_ctrl.sv
// Bench for usrt_apb_ctrl: vector table of TX/RX frames plus hand-written
// corner sequences (timeout, abort, STATUS, reset mid-frame), scoreboard on pReady.
module tb_usrt_apb_ctrl;
    localparam int CPB    = 40;
    localparam int HALF   = CPB / 2;
    localparam int ADDR_W = 33;
    localparam int RXTO   = 16;
`ifdef USRT_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic              pClk = 1'b0;
    logic              pReset;
    logic              pSelect, pEnable, pWrite;
    logic [ADDR_W-1:0] pAddress;
    logic [7:0]        pWData, pRData;
    logic              pReady, pSlvErr, usrt_clk, usrt_tx, usrt_rx;

    usrt_apb_ctrl #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .RX_TIMEOUT(RXTO)) dut (
        .pClk(pClk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable),
        .pWrite(pWrite), .pAddress(pAddress), .pWData(pWData), .pRData(pRData),
        .pReady(pReady), .pSlvErr(pSlvErr), .usrt_clk(usrt_clk), .usrt_tx(usrt_tx),
        .usrt_rx(usrt_rx)
    );

    always #5 pClk = ~pClk;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        int         delay;
        logic       stop;
        logic       pflip;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic       chk_rd;
        logic [7:0] rdata;
        logic       err;
    } sb_t;

    vec_t  vt[$];
    sb_t   sb[$];
    sb_t   mon_e;
    string cur_name = "init";
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            if (lo == hi) $display("FAIL %s: got=0x%0h expected=0x%0h", nm, act, lo);
            else          $display("FAIL %s: got=%0d expected=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic stop,
                                               input logic pflip);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef USRT_PARITY_EN
        f[9]   = (^d) ^ pflip;
        f[10]  = stop;
`else
        f[9]   = stop;
`endif
        return f;
    endfunction

    // Scoreboard: every pReady pulse must match a queued expectation
    always @(negedge pClk) begin
        if (pReady) begin
            if (sb.size() == 0) begin
                check({cur_name, "_spurious_pready"}, 1, 0, 0);
            end else begin
                mon_e = sb.pop_front();
                check({cur_name, "_pslverr"}, int'(pSlvErr), int'(mon_e.err), int'(mon_e.err));
                if (mon_e.chk_rd)
                    check({cur_name, "_prdata"}, int'(pRData), int'(mon_e.rdata), int'(mon_e.rdata));
            end
        end
    end

    task automatic run_access(input logic addr, input logic wr, input logic [7:0] wd,
                              input logic drive_rx, input int delay, input logic stop,
                              input logic pflip, input int lat_min, input int lat_max,
                              input logic chk_rd, input logic [7:0] exp_rd,
                              input logic exp_err, input string name);
        sb_t         e;
        logic [10:0] fb;
        logic [10:0] got;
        int          lat;
        bit          seen;
        cur_name = name;
        e.chk_rd = chk_rd;
        e.rdata  = exp_rd;
        e.err    = exp_err;
        sb.push_back(e);
        fb   = frame_bits(wd, stop, pflip);
        got  = '1;
        seen = 1'b0;
        lat  = 0;
        @(posedge pClk); #1;
        pSelect  = 1'b1;
        pEnable  = 1'b0;
        pWrite   = wr;
        pAddress = ADDR_W'(addr);
        pWData   = wd;
        @(posedge pClk); #1;
        pEnable = 1'b1;
        for (int c = 0; c <= lat_max + 2 && !seen; c++) begin
            @(negedge pClk);
            if (drive_rx)
                for (int k = 0; k < NB; k++)
                    if (c == 1 + (delay + k) * CPB) usrt_rx = fb[k];
            if (wr && !addr && c >= 1 && c < 1 + NB * CPB && ((c - 1) % CPB) == HALF)
                got[(c - 1) / CPB] = usrt_tx;
            if (pReady) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        if (!seen) check({name, "_pready_timeout"}, 0, 1, 1);
        else       check({name, "_latency"}, lat, lat_min, lat_max);
        if (wr && !addr) check({name, "_tx_bits"}, int'(got), int'(fb), int'(fb));
        @(posedge pClk); #1;
        pSelect = 1'b0;
        pEnable = 1'b0;
        usrt_rx = 1'b1;
    endtask

    task automatic status_read(input logic [7:0] exp, input string name);
        run_access(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1, 1, 1'b1, exp, 1'b0, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        pReset = 1'b0; pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
        pAddress = '0; pWData = '0; usrt_rx = 1'b1;
        repeat (2) @(posedge pClk);
        @(negedge pClk);
        check("rst_usrt_tx",   int'(usrt_tx),  1, 1);
        check("rst_pready",    int'(pReady),   0, 0);
        check("rst_prdata",    int'(pRData),   0, 0);
        check("rst_usrt_clk",  int'(usrt_clk), 0, 0);
        check("rst_pslverr",   int'(pSlvErr),  0, 0);
        pReset = 1'b1;

        vt.push_back('{1'b1, 8'hA5, 0, 1'b1, 1'b0, 8'h00, 1'b0});
        vt.push_back('{1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00, 1'b0});
        vt.push_back('{1'b1, 8'hFF, 0, 1'b1, 1'b0, 8'h00, 1'b0});
        vt.push_back('{1'b0, 8'hE2, 0, 1'b1, 1'b0, 8'hE2, 1'b0});
        vt.push_back('{1'b0, 8'h3C, 3, 1'b1, 1'b0, 8'h3C, 1'b0});
`ifdef USRT_PARITY_EN
        vt.push_back('{1'b1, 8'h07, 0, 1'b1, 1'b0, 8'h00, 1'b0});
        vt.push_back('{1'b0, 8'h07, 1, 1'b1, 1'b1, 8'h07, 1'b1});
        vt.push_back('{1'b0, 8'h96, 0, 1'b1, 1'b0, 8'h96, 1'b0});
`endif
        vt.push_back('{1'b0, 8'h81, 1, 1'b0, 1'b0, 8'h81, 1'b1});

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].wr) begin
                lat = 1 + NB * CPB;
                run_access(1'b0, 1'b1, vt[i].data, 1'b0, 0, 1'b1, 1'b0, lat, lat,
                           1'b0, 8'h00, 1'b0, $sformatf("vec%0d_tx", i));
            end else begin
                lat = 1 + (vt[i].delay + NB - 1) * CPB + HALF + 1;
                run_access(1'b0, 1'b0, vt[i].data, 1'b1, vt[i].delay, vt[i].stop, vt[i].pflip,
                           lat, lat, 1'b1, vt[i].exp_rd, vt[i].exp_err,
                           $sformatf("vec%0d_rx", i));
            end
        end

        status_read(8'h02, "stat_after_stop_err");
        status_read(8'h00, "stat_cleared");

        run_access(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1 + RXTO * CPB, 1 + RXTO * CPB + 1,
                   1'b1, 8'h00, 1'b1, "rx_timeout");
        status_read(8'h02, "stat_after_timeout");

        // Abort: drop pSelect during bit 4 of a TX frame of 8'h00
        cur_name = "abort";
        @(posedge pClk); #1;
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddress = '0; pWData = 8'h00;
        @(posedge pClk); #1;
        pEnable = 1'b1;
        repeat (1 + 4 * CPB + 5) @(negedge pClk);
        check("abort_tx_before",  int'(usrt_tx),  0, 0);
        check("abort_clk_before", int'(usrt_clk), 1, 1);
        pSelect = 1'b0; pEnable = 1'b0;
        @(negedge pClk);
        check("abort_tx_after",  int'(usrt_tx),  1, 1);
        check("abort_clk_after", int'(usrt_clk), 0, 0);
        check("abort_pready",    int'(pReady),   0, 0);
        repeat (6 * CPB) @(negedge pClk);
        check("abort_tx_idle", int'(usrt_tx), 1, 1);
        status_read(8'h00, "stat_after_abort");

        run_access(1'b1, 1'b1, 8'hFF, 1'b0, 0, 1'b1, 1'b0, 1, 1, 1'b0, 8'h00, 1'b0, "stat_write");
        status_read(8'h00, "stat_after_write");

        run_access(1'b0, 1'b0, 8'h5A, 1'b1, 0, 1'b1, 1'b0, 1 + (NB - 1) * CPB + HALF + 1,
                   1 + (NB - 1) * CPB + HALF + 1, 1'b1, 8'h5A, 1'b0, "rx_5a");

        // Reset in the middle of a TX frame of 8'h00 (bit 2)
        cur_name = "rst_mid";
        @(posedge pClk); #1;
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddress = '0; pWData = 8'h00;
        @(posedge pClk); #1;
        pEnable = 1'b1;
        repeat (2 * CPB + 10) @(negedge pClk);
        check("rst_mid_tx_before", int'(usrt_tx), 0, 0);
        pReset = 1'b0;
        @(negedge pClk);
        check("rst_mid_tx",     int'(usrt_tx),  1, 1);
        check("rst_mid_clk",    int'(usrt_clk), 0, 0);
        check("rst_mid_pready", int'(pReady),   0, 0);
        check("rst_mid_prdata", int'(pRData),   0, 0);
        pReset = 1'b1; pSelect = 1'b0; pEnable = 1'b0;
        repeat (2 * CPB) @(negedge pClk);
        check("rst_mid_tx_idle", int'(usrt_tx), 1, 1);
        status_read(8'h00, "stat_after_reset");

        repeat (5) @(negedge pClk);
        check("sb_drained", sb.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
